// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer and the datapath top.
// Holds the FSM state encoding, the hazard priority order and the control bundle.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 5;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } hz_state_e;

  // Higher value wins when several hazards are raised in one cycle.
  typedef enum logic [1:0] {
    PRI_NONE     = 2'd0,
    PRI_LOAD_USE = 2'd1,
    PRI_BRANCH   = 2'd2,
    PRI_MEM      = 2'd3
  } hz_pri_e;

  typedef struct packed {
    logic pc_hold;
    logic if_id_hold;
    logic if_id_flush;
    logic id_ex_bubble;
    logic pipe_freeze;
  } pipe_ctrl_t;

  function automatic hz_pri_e hz_priority(input logic mem_stall,
                                          input logic branch,
                                          input logic load_use);
    if (mem_stall)     return PRI_MEM;
    else if (branch)   return PRI_BRANCH;
    else if (load_use) return PRI_LOAD_USE;
    else               return PRI_NONE;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the ID sources and the EX load target.
// x0 is never a real dependency, so a load into it raises nothing.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic                 ex_valid,
  input  logic                 ex_is_load,
  input  logic [REG_IDX_W-1:0] ex_rd,
  output logic                 hazard
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit = id_rs1_used && (id_rs1 == ex_rd);
  assign rs2_hit = id_rs2_used && (id_rs2 == ex_rd);
  assign hazard  = ex_valid && ex_is_load && id_valid && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes,
// data-memory wait freeze with timeout abort, plus saturating stall/flush counters.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT       = 255,
  parameter int unsigned CNT_W             = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic                 ex_valid,
  input  logic                 ex_is_load,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_hold,
  output logic                 if_id_hold,
  output logic                 if_id_flush,
  output logic                 id_ex_bubble,
  output logic                 pipe_freeze,
  output logic                 mem_timeout,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_events
);

  localparam int unsigned          WAIT_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [1:0]           LOAD_RELOAD = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [WAIT_W-1:0]    WAIT_LIMIT  = WAIT_W'(MEM_TIMEOUT);

  logic              load_use, mem_stall, timeout_hit, mem_timeout_q;
  hz_pri_e           pri;
  hz_state_e         state_q, state_d;
  logic [1:0]        stall_cnt, stall_cnt_d;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_d;
  pipe_ctrl_t        ctrl;
  logic [CNT_W-1:0]  stall_cycles_q, flush_events_q;

  load_use_detect u_load_use_detect (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_valid    (ex_valid),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .hazard      (load_use)
  );

  assign mem_stall = mem_req && !mem_ready;
  assign pri       = hz_priority(mem_stall, ex_branch_taken, load_use);

  always_comb begin
    ctrl        = '0;
    state_d     = state_q;
    stall_cnt_d = stall_cnt;
    wait_cnt_d  = wait_cnt;
    timeout_hit = 1'b0;
    case (state_q)
      ST_RUN: begin
        case (pri)
          PRI_MEM: begin
            ctrl.pc_hold     = 1'b1;
            ctrl.if_id_hold  = 1'b1;
            ctrl.pipe_freeze = 1'b1;
            state_d          = ST_MEM_WAIT;
            wait_cnt_d       = WAIT_W'(1);
          end
          PRI_BRANCH: begin
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_bubble = 1'b1;
          end
          PRI_LOAD_USE: begin
            ctrl.pc_hold      = 1'b1;
            ctrl.if_id_hold   = 1'b1;
            ctrl.id_ex_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d     = ST_LOAD_STALL;
              stall_cnt_d = LOAD_RELOAD;
            end
          end
          default: ;
        endcase
      end
      ST_LOAD_STALL: begin
        // Remaining bubbles are parked while memory stalls and resumed afterwards.
        if (pri == PRI_MEM) begin
          ctrl.pc_hold     = 1'b1;
          ctrl.if_id_hold  = 1'b1;
          ctrl.pipe_freeze = 1'b1;
          state_d          = ST_MEM_WAIT;
          wait_cnt_d       = WAIT_W'(1);
        end else begin
          ctrl.pc_hold      = 1'b1;
          ctrl.if_id_hold   = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
          stall_cnt_d       = stall_cnt - 2'd1;
          if (stall_cnt == 2'd1) state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        ctrl.pc_hold     = 1'b1;
        ctrl.if_id_hold  = 1'b1;
        ctrl.pipe_freeze = 1'b1;
        wait_cnt_d       = wait_cnt + WAIT_W'(1);
        if (mem_ready) begin
          state_d    = (stall_cnt != 2'd0) ? ST_LOAD_STALL : ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt == WAIT_LIMIT) begin
          // Abort: discard the younger instructions and restart from RUN.
          timeout_hit       = 1'b1;
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
          state_d           = ST_RUN;
          stall_cnt_d       = '0;
          wait_cnt_d        = '0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      stall_cnt      <= '0;
      wait_cnt       <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_cnt     <= stall_cnt_d;
      wait_cnt      <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_q | timeout_hit;
      if (ctrl.pc_hold && !(&stall_cycles_q))
        stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      if (ctrl.if_id_flush && !(&flush_events_q))
        flush_events_q <= flush_events_q + CNT_W'(1);
    end
  end

  assign pc_hold      = ctrl.pc_hold;
  assign if_id_hold   = ctrl.if_id_hold;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign pipe_freeze  = ctrl.pipe_freeze;
  assign mem_timeout  = mem_timeout_q;
  assign state        = state_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two configurations driven by shared stimulus,
// each compared every cycle against a bubble-debt reference model.
module tb_pipeline_hazard_ctrl;

  localparam int LA = 2, TA = 4, WA = 16;
  localparam int LB = 3, TB = 3, WB = 3;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_rs1_used, id_rs2_used, ex_valid, ex_is_load, ex_branch_taken;
  logic mem_req, mem_ready;
  logic [4:0] id_rs1, id_rs2, ex_rd;

  logic pc_hold_a, if_id_hold_a, if_id_flush_a, id_ex_bubble_a, pipe_freeze_a, mem_timeout_a;
  logic [1:0] state_a;
  logic [WA-1:0] stall_cycles_a, flush_events_a;
  logic pc_hold_b, if_id_hold_b, if_id_flush_b, id_ex_bubble_b, pipe_freeze_b, mem_timeout_b;
  logic [1:0] state_b;
  logic [WB-1:0] stall_cycles_b, flush_events_b;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(LA), .MEM_TIMEOUT(TA), .CNT_W(WA)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_valid(ex_valid),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_hold(pc_hold_a), .if_id_hold(if_id_hold_a),
    .if_id_flush(if_id_flush_a), .id_ex_bubble(id_ex_bubble_a), .pipe_freeze(pipe_freeze_a),
    .mem_timeout(mem_timeout_a), .state(state_a), .stall_cycles(stall_cycles_a),
    .flush_events(flush_events_a)
  );

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(LB), .MEM_TIMEOUT(TB), .CNT_W(WB)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_valid(ex_valid),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_hold(pc_hold_b), .if_id_hold(if_id_hold_b),
    .if_id_flush(if_id_flush_b), .id_ex_bubble(id_ex_bubble_b), .pipe_freeze(pipe_freeze_b),
    .mem_timeout(mem_timeout_b), .state(state_b), .stall_cycles(stall_cycles_b),
    .flush_events(flush_events_b)
  );

  // owed = bubbles still due after the current one; waiting = memory access outstanding.
  typedef struct {
    int owed; bit waiting; int waited; bit to; int stalls; int flushes;
  } mdl_t;
  typedef struct {
    bit [4:0] ctl; int st; bit to; int stalls; int flushes;
  } exp_t;

  mdl_t ma, mb;
  int nerr = 0, nchk = 0;
  logic last_freeze_a, last_bubble_a;
  logic [4:0] last_ctl_a;

  function automatic mdl_t model_step(input int L, input int T, input int W,
                                      input mdl_t m, output exp_t e);
    mdl_t n = m;
    bit hold = 0, ifh = 0, fl = 0, bub = 0, frz = 0;
    bit hz, ms;
    int sat = (1 << W) - 1;
    hz = ex_valid && ex_is_load && id_valid && ex_rd != 0 &&
         ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    ms = mem_req && !mem_ready;
    e.st = m.waiting ? 2 : (m.owed > 0 ? 1 : 0);
    e.to = m.to; e.stalls = m.stalls; e.flushes = m.flushes;
    if (m.waiting) begin
      hold = 1; ifh = 1; frz = 1; n.waited = m.waited + 1;
      if (mem_ready) begin
        n.waiting = 0; n.waited = 0;
      end else if (m.waited == T) begin
        fl = 1; bub = 1; n.to = 1; n.waiting = 0; n.owed = 0; n.waited = 0;
      end
    end else if (ms) begin
      hold = 1; ifh = 1; frz = 1; n.waiting = 1; n.waited = 1;
    end else if (m.owed > 0) begin
      hold = 1; ifh = 1; bub = 1; n.owed = m.owed - 1;
    end else if (ex_branch_taken) begin
      fl = 1; bub = 1;
    end else if (hz) begin
      hold = 1; ifh = 1; bub = 1; n.owed = L - 1;
    end
    e.ctl = {hold, ifh, fl, bub, frz};
    if (hold && m.stalls < sat) n.stalls = m.stalls + 1;
    if (fl && m.flushes < sat) n.flushes = m.flushes + 1;
    if (rst) n = '{default: 0};
    return n;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    exp_t ea, eb;
    @(negedge clk);
    ma = model_step(LA, TA, WA, ma, ea);
    mb = model_step(LB, TB, WB, mb, eb);
    last_ctl_a    = {pc_hold_a, if_id_hold_a, if_id_flush_a, id_ex_bubble_a, pipe_freeze_a};
    last_freeze_a = pipe_freeze_a;
    last_bubble_a = id_ex_bubble_a;
    cmp("a_ctl",   {27'd0, last_ctl_a}, {27'd0, ea.ctl});
    cmp("a_state", {30'd0, state_a}, 32'(ea.st));
    cmp("a_tmo",   {31'd0, mem_timeout_a}, {31'd0, ea.to});
    cmp("a_stall", {16'd0, stall_cycles_a}, 32'(ea.stalls));
    cmp("a_flush", {16'd0, flush_events_a}, 32'(ea.flushes));
    cmp("b_ctl",   {27'd0, pc_hold_b, if_id_hold_b, if_id_flush_b, id_ex_bubble_b, pipe_freeze_b},
                   {27'd0, eb.ctl});
    cmp("b_state", {30'd0, state_b}, 32'(eb.st));
    cmp("b_tmo",   {31'd0, mem_timeout_b}, {31'd0, eb.to});
    cmp("b_stall", {29'd0, stall_cycles_b}, 32'(eb.stalls));
    cmp("b_flush", {29'd0, flush_events_b}, 32'(eb.flushes));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
    ex_valid = 0; ex_is_load = 0; ex_rd = '0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic load_use(input logic [4:0] rd);
    idle(); id_valid = 1; ex_valid = 1; ex_is_load = 1; ex_rd = rd; id_rs1 = rd; id_rs1_used = 1;
  endtask

  initial begin
    int fz, bb;
    idle(); rst = 1;
    ma = '{default: 0}; mb = '{default: 0};
    repeat (2) @(posedge clk);
    #1;
    // reset state with all inputs low
    tick(); tick();
    rst = 0;

    // load-use on x5, two-cycle stall in dut_a
    do_reset();
    load_use(5'd5); tick(); bb = int'(last_bubble_a);
    idle(); tick(); bb += int'(last_bubble_a);
    tick(); bb += int'(last_bubble_a);
    cmp("lu_bubbles", 32'(bb), 32'd2);
    cmp("lu_stalls", {16'd0, stall_cycles_a}, 32'd2);
    cmp("lu_state", {30'd0, state_a}, 32'd0);

    // load into x0 is not a hazard
    do_reset();
    load_use(5'd0); tick();
    cmp("x0_ctl", {27'd0, last_ctl_a}, 32'd0);

    // branch wins over simultaneous load-use
    do_reset();
    load_use(5'd7); ex_branch_taken = 1; tick();
    cmp("br_ctl", {27'd0, last_ctl_a}, 32'b00110);
    idle(); tick();
    cmp("br_flushes", {16'd0, flush_events_a}, 32'd1);
    cmp("br_stalls", {16'd0, stall_cycles_a}, 32'd0);
    cmp("br_state", {30'd0, state_a}, 32'd0);

    // memory wait, branch pulse ignored while frozen
    do_reset();
    fz = 0;
    mem_req = 1; tick(); fz += int'(last_freeze_a);
    ex_branch_taken = 1; tick(); fz += int'(last_freeze_a);
    ex_branch_taken = 0; tick(); fz += int'(last_freeze_a);
    mem_ready = 1; tick(); fz += int'(last_freeze_a);
    idle(); tick(); fz += int'(last_freeze_a);
    cmp("mw_freeze", 32'(fz), 32'd4);
    cmp("mw_state", {30'd0, state_a}, 32'd0);
    cmp("mw_flushes", {16'd0, flush_events_a}, 32'd0);

    // memory never ready: timeout abort, sticky flag
    do_reset();
    mem_req = 1;
    repeat (5) tick();
    idle();
    repeat (5) tick();
    cmp("to_flag", {31'd0, mem_timeout_a}, 32'd1);
    cmp("to_state", {30'd0, state_a}, 32'd0);
    cmp("to_flushes", {16'd0, flush_events_a}, 32'd1);

    // reset in the middle of a three-cycle load stall
    do_reset();
    load_use(5'd9); tick();
    idle(); rst = 1; tick();
    idle(); #1;
    cmp("rst_state", {30'd0, state_b}, 32'd0);
    cmp("rst_stalls", {29'd0, stall_cycles_b}, 32'd0);
    cmp("rst_hold", {31'd0, pc_hold_b}, 32'd0);
    tick();

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      rst             = ($urandom_range(0, 79) == 0);
      id_valid        = ($urandom_range(0, 3) != 0);
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      id_rs1_used     = ($urandom_range(0, 1) == 1);
      id_rs2_used     = ($urandom_range(0, 1) == 1);
      ex_valid        = ($urandom_range(0, 3) != 0);
      ex_is_load      = ($urandom_range(0, 1) == 1);
      ex_rd           = 5'($urandom_range(0, 3));
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      mem_req         = ($urandom_range(0, 5) == 0);
      mem_ready       = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
